// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core definitions.
//   XLEN      - architectural register data width
//   AW        - register index width (2**AW architectural registers)
//   reg_idx_t - register index type
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_idx_t;

endpackage : riscv_pkg

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: write-back port bundle between the pipeline/LSU and the
// write-back arbiter.
//   master - pipeline side: drives ALU/LSU results, sees stall/ready/write port
//   slave  - arbiter side: consumes results, drives stall/ready/write port
interface wb_arbiter_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int AW   = riscv_pkg::AW
);

    logic               alu_valid;
    logic [AW-1:0]      alu_rd;
    logic [XLEN-1:0]    alu_data;
    logic               stall;
    logic               lsu_valid;
    logic               lsu_ready;
    logic [AW-1:0]      lsu_rd;
    logic [XLEN-1:0]    lsu_data;
    logic               RegWrite;
    logic [AW-1:0]      WriteRegister;
    logic [XLEN-1:0]    RegWriteData;
    logic [2**AW-1:0]   pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  stall, lsu_ready, RegWrite, WriteRegister, RegWriteData, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output stall, lsu_ready, RegWrite, WriteRegister, RegWriteData, pending_mask
    );

endinterface : wb_arbiter_if

// File: rtl/wb_fifo.sv
// wb_fifo: small circular FIFO holding LSU write-back entries {rd, data}.
//   clk, reset      - clock, asynchronous active-high reset (empties the queue)
//   push, din       - enqueue din (ignored while full, even with a same-cycle pop)
//   pop, dout       - dequeue; dout is the current head
//   full, empty     - status from registered occupancy
//   count           - registered occupancy
//   slot_tag/valid  - per-slot tag field (top TAGW bits) and validity, so the
//                     owner can decode outstanding destinations
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int TAGW  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                din,
    output logic [W-1:0]                dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DEPTH-1:0][TAGW-1:0]  slot_tag,
    output logic [DEPTH-1:0]            slot_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW:0]             count_q, count_d;
    logic                    do_push_s, do_pop_s;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == {(PW+1){1'b0}});
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Slot i is live when its distance from the read pointer is below occupancy.
    always_comb begin
        slot_tag   = '0;
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off           = PW'(i) - rd_ptr_q;
            slot_tag[i]   = mem_q[i][W-1 -: TAGW];
            slot_valid[i] = ({1'b0, off} < count_q);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : wb_fifo

// File: rtl/wb_arbiter.sv
// wb_arbiter: single register-file write port shared by the ALU (fixed
// 1-cycle latency, priority) and the LSU (buffered through wb_fifo).
//   clk, reset - clock, asynchronous active-high reset
//   bus.slave  - ALU result in, stall out; LSU valid/ready/rd/data;
//                registered RegWrite/WriteRegister/RegWriteData;
//                pending_mask of destinations still queued for the LSU.
// The ALU wins by default; after STARVE_MAX consecutive ALU wins with LSU
// work waiting, stall forces one LSU write through.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int AW         = riscv_pkg::AW,
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);

    localparam int EW = AW + XLEN;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                       fifo_full_s, fifo_empty_s;
    logic [$clog2(QDEPTH):0]    fifo_count_s;
    logic [EW-1:0]              head_s;
    logic [QDEPTH-1:0][AW-1:0]  slot_tag_s;
    logic [QDEPTH-1:0]          slot_valid_s;
    logic                       queued_s, stall_s, alu_win_s, lsu_win_s;
    logic                       push_s, lsu_ready_s;
    logic [2**AW-1:0]           pending_s;

    logic                       regwrite_q, regwrite_d;
    logic [AW-1:0]              wreg_q, wreg_d;
    logic [XLEN-1:0]            wdata_q, wdata_d;
    logic [SW-1:0]              starve_q, starve_d;

    // Readiness depends only on registered occupancy, never on this cycle's pop.
    assign lsu_ready_s = !reset && !fifo_full_s;
    assign queued_s    = (fifo_count_s != '0);
    assign stall_s     = (starve_q == SW'(STARVE_MAX)) && queued_s;
    assign alu_win_s   = bus.alu_valid && !stall_s;
    assign lsu_win_s   = !alu_win_s && !fifo_empty_s;
    // x0 results complete the handshake but are dropped here.
    assign push_s      = bus.lsu_valid && lsu_ready_s && (bus.lsu_rd != {AW{1'b0}});

    wb_fifo #(.DEPTH(QDEPTH), .W(EW), .TAGW(AW)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .pop        (lsu_win_s),
        .din        ({bus.lsu_rd, bus.lsu_data}),
        .dout       (head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s),
        .slot_tag   (slot_tag_s),
        .slot_valid (slot_valid_s)
    );

    // Outstanding-destination mask; duplicates simply OR into the same bit.
    always_comb begin
        pending_s = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (slot_valid_s[i]) begin
                pending_s[slot_tag_s[i]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
    end

    // Winner selection and write-port next state; ALU x0 writes are dropped.
    always_comb begin
        regwrite_d = 1'b0;
        wreg_d     = {AW{1'b0}};
        wdata_d    = {XLEN{1'b0}};
        if (alu_win_s) begin
            if (bus.alu_rd != {AW{1'b0}}) begin
                regwrite_d = 1'b1;
                wreg_d     = bus.alu_rd;
                wdata_d    = bus.alu_data;
            end else begin
                regwrite_d = 1'b0;
            end
        end else if (lsu_win_s) begin
            regwrite_d = 1'b1;
            wreg_d     = head_s[XLEN +: AW];
            wdata_d    = head_s[XLEN-1:0];
        end else begin
            regwrite_d = 1'b0;
        end
    end

    // Starvation counter: counts ALU wins while LSU work waits, saturating.
    always_comb begin
        starve_d = starve_q;
        if (!queued_s || lsu_win_s) begin
            starve_d = {SW{1'b0}};
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Write-port and starvation registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            wreg_q     <= {AW{1'b0}};
            wdata_q    <= {XLEN{1'b0}};
            starve_q   <= {SW{1'b0}};
        end else begin
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.stall         = stall_s;
    assign bus.lsu_ready     = lsu_ready_s;
    assign bus.RegWrite      = regwrite_q;
    assign bus.WriteRegister = wreg_q;
    assign bus.RegWriteData  = wdata_q;
    assign bus.pending_mask  = pending_s;

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of the write-back arbitration rules.
module tb_wb_arbiter;
    import riscv_pkg::*;

    localparam int XL = 32;
    localparam int A  = 5;
    localparam int QD = 2;
    localparam int SM = 4;

    typedef struct {
        logic        stall;
        logic        ready;
        logic [31:0] pend;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] pend_post;
    } snap_t;

    logic clk;
    logic reset;

    wb_arbiter_if #(.XLEN(XL), .AW(A)) bus ();

    wb_arbiter #(.XLEN(XL), .AW(A), .QDEPTH(QD), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    snap_t       exp_s, obs_s;
    reg_idx_t    q_rd[$];
    logic [31:0] q_dat[$];
    int          starve;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_pend();
        logic [31:0] m = 32'h0;
        foreach (q_rd[i]) m[q_rd[i]] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        q_rd.delete();
        q_dat.delete();
        starve = 0;
    endtask

    // One clock: drive inputs, record pre-edge observations, advance model and DUT.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit alu_w, was_empty, accept, popped;
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
        bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_data = ld;
        #1;
        exp_s.stall = (starve == SM) && (q_rd.size() > 0);
        exp_s.ready = (q_rd.size() < QD);
        exp_s.pend  = model_pend();
        obs_s.stall = bus.stall;
        obs_s.ready = bus.lsu_ready;
        obs_s.pend  = bus.pending_mask;
        alu_w     = av && !exp_s.stall;
        was_empty = (q_rd.size() == 0);
        accept    = lv && exp_s.ready;
        popped    = 0;
        exp_s.rw = 1'b0; exp_s.wr = 5'd0; exp_s.wd = 32'h0;
        if (alu_w) begin
            if (ard != 5'd0) begin
                exp_s.rw = 1'b1; exp_s.wr = ard; exp_s.wd = ad;
            end
        end else if (!was_empty) begin
            exp_s.rw = 1'b1;
            exp_s.wr = q_rd.pop_front();
            exp_s.wd = q_dat.pop_front();
            popped   = 1;
        end
        if (was_empty || popped) starve = 0;
        else if (starve < SM) starve++;
        if (accept && lrd != 5'd0) begin
            q_rd.push_back(lrd);
            q_dat.push_back(ld);
        end
        exp_s.pend_post = model_pend();
        @(posedge clk);
        #1;
        obs_s.rw        = bus.RegWrite;
        obs_s.wr        = bus.WriteRegister;
        obs_s.wd        = bus.RegWriteData;
        obs_s.pend_post = bus.pending_mask;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'h0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h0;
        model_clear();
        @(posedge clk); #1;
        tests_run += 6;
        if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL rst_regwrite: got %b want 0", bus.RegWrite); end
        if (bus.WriteRegister !== 5'd0) begin tests_failed++; $display("FAIL rst_wreg: got %0d want 0", bus.WriteRegister); end
        if (bus.RegWriteData !== 32'h0) begin tests_failed++; $display("FAIL rst_wdata: got %h want 0", bus.RegWriteData); end
        if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        if (bus.pending_mask !== 32'h0) begin tests_failed++; $display("FAIL rst_pending: got %h want 0", bus.pending_mask); end
        if (bus.lsu_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %b want 0", bus.lsu_ready); end
        #3 reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bus.lsu_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b want 1", bus.lsu_ready); end
    endtask

    task automatic test_alu_only();
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        tests_run += 3;
        if (obs_s.rw !== 1'b1) begin tests_failed++; $display("FAIL alu_rw: got %b want 1", obs_s.rw); end
        if (obs_s.wr !== 5'd5) begin tests_failed++; $display("FAIL alu_wr: got %0d want 5", obs_s.wr); end
        if (obs_s.wd !== 32'h1234) begin tests_failed++; $display("FAIL alu_wd: got %h want 1234", obs_s.wd); end
        idle();
        tests_run++;
        if (obs_s.rw !== 1'b0) begin tests_failed++; $display("FAIL alu_idle_rw: got %b want 0", obs_s.rw); end
    endtask

    task automatic test_lsu_only();
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD);
        tests_run += 3;
        if (obs_s.ready !== 1'b1) begin tests_failed++; $display("FAIL lsu_ready: got %b want 1", obs_s.ready); end
        if (obs_s.rw !== 1'b0) begin tests_failed++; $display("FAIL lsu_early_rw: got %b want 0", obs_s.rw); end
        if (obs_s.pend_post !== 32'h80) begin tests_failed++; $display("FAIL lsu_pending: got %h want 00000080", obs_s.pend_post); end
        idle();
        tests_run += 4;
        if (obs_s.rw !== 1'b1) begin tests_failed++; $display("FAIL lsu_rw: got %b want 1", obs_s.rw); end
        if (obs_s.wr !== 5'd7) begin tests_failed++; $display("FAIL lsu_wr: got %0d want 7", obs_s.wr); end
        if (obs_s.wd !== 32'hDEAD) begin tests_failed++; $display("FAIL lsu_wd: got %h want dead", obs_s.wd); end
        if (obs_s.pend_post !== 32'h0) begin tests_failed++; $display("FAIL lsu_pending_clr: got %h want 0", obs_s.pend_post); end
    endtask

    task automatic test_contention();
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h900);
        tests_run++;
        if (obs_s.wr !== 5'd1) begin tests_failed++; $display("FAIL cont_first_wr: got %0d want 1", obs_s.wr); end
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 5'(k + 1), 32'h100 + 32'(k), 1'b0, 5'd0, 32'h0);
            tests_run += 2;
            if (obs_s.stall !== 1'b0) begin tests_failed++; $display("FAIL cont_stall_%0d: got %b want 0", k, obs_s.stall); end
            if (obs_s.rw !== 1'b1 || obs_s.wr !== 5'(k + 1)) begin
                tests_failed++; $display("FAIL cont_alu_%0d: got rw=%b wr=%0d want rw=1 wr=%0d", k, obs_s.rw, obs_s.wr, k + 1);
            end
        end
        step(1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'h0);
        tests_run += 2;
        if (obs_s.stall !== 1'b1) begin tests_failed++; $display("FAIL cont_stall_hi: got %b want 1", obs_s.stall); end
        if (obs_s.wr !== 5'd9 || obs_s.wd !== 32'h900) begin
            tests_failed++; $display("FAIL cont_lsu: got wr=%0d wd=%h want wr=9 wd=900", obs_s.wr, obs_s.wd);
        end
        step(1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'h0);
        tests_run += 2;
        if (obs_s.stall !== 1'b0) begin tests_failed++; $display("FAIL cont_resume_stall: got %b want 0", obs_s.stall); end
        if (obs_s.wr !== 5'd6 || obs_s.wd !== 32'h600) begin
            tests_failed++; $display("FAIL cont_resume: got wr=%0d wd=%h want wr=6 wd=600", obs_s.wr, obs_s.wd);
        end
    endtask

    task automatic test_full();
        int  refused;
        bit  accepted, saw11;
        logic [4:0] want_wr[3];
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd11, 32'hB11);
        step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd12, 32'hB12);
        tests_run++;
        if (obs_s.pend_post !== 32'h1800) begin tests_failed++; $display("FAIL full_pending: got %h want 00001800", obs_s.pend_post); end
        refused = 0; accepted = 0; saw11 = 0;
        for (int n = 0; n < 10 && !accepted; n++) begin
            step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd13, 32'hB13);
            if (obs_s.ready) accepted = 1;
            else refused++;
            if (obs_s.rw && obs_s.wr == 5'd11) saw11 = 1;
        end
        tests_run += 3;
        if (!accepted) begin tests_failed++; $display("FAIL full_accept: got never-accepted want accepted"); end
        if (refused !== 4) begin tests_failed++; $display("FAIL full_refused: got %0d want 4", refused); end
        if (!saw11) begin tests_failed++; $display("FAIL full_pop_first: got no x11 write want x11 before accept"); end
        want_wr[0] = 5'd12; want_wr[1] = 5'd13; want_wr[2] = 5'd0;
        for (int n = 0; n < 3; n++) begin
            idle();
            tests_run++;
            if (obs_s.wr !== want_wr[n] || obs_s.rw !== (want_wr[n] != 5'd0)) begin
                tests_failed++; $display("FAIL full_drain_%0d: got rw=%b wr=%0d want wr=%0d", n, obs_s.rw, obs_s.wr, want_wr[n]);
            end
        end
    endtask

    task automatic test_x0();
        step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
        tests_run++;
        if (obs_s.rw !== 1'b0) begin tests_failed++; $display("FAIL x0_alu: got %b want 0", obs_s.rw); end
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD);
        tests_run += 2;
        if (obs_s.ready !== 1'b1) begin tests_failed++; $display("FAIL x0_lsu_ready: got %b want 1", obs_s.ready); end
        if (obs_s.pend_post !== 32'h0) begin tests_failed++; $display("FAIL x0_pending: got %h want 0", obs_s.pend_post); end
        idle();
        tests_run++;
        if (obs_s.rw !== 1'b0) begin tests_failed++; $display("FAIL x0_lsu_write: got %b want 0", obs_s.rw); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 5'd1, 32'hC1, 1'b1, 5'd14, 32'hE14);
        step(1'b1, 5'd2, 32'hC2, 1'b1, 5'd15, 32'hE15);
        #2 reset = 1'b1;
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        #1;
        model_clear();
        tests_run += 5;
        if (bus.RegWrite !== 1'b0) begin tests_failed++; $display("FAIL mid_regwrite: got %b want 0", bus.RegWrite); end
        if (bus.WriteRegister !== 5'd0) begin tests_failed++; $display("FAIL mid_wreg: got %0d want 0", bus.WriteRegister); end
        if (bus.RegWriteData !== 32'h0) begin tests_failed++; $display("FAIL mid_wdata: got %h want 0", bus.RegWriteData); end
        if (bus.pending_mask !== 32'h0) begin tests_failed++; $display("FAIL mid_pending: got %h want 0", bus.pending_mask); end
        if (bus.lsu_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready: got %b want 0", bus.lsu_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bus.lsu_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_release_ready: got %b want 1", bus.lsu_ready); end
        for (int n = 0; n < 3; n++) begin
            idle();
            tests_run++;
            if (obs_s.rw !== 1'b0) begin tests_failed++; $display("FAIL mid_no_write_%0d: got %b want 0", n, obs_s.rw); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom());
            tests_run += 4;
            if (obs_s.stall !== exp_s.stall) begin tests_failed++; $display("FAIL rnd_stall@%0d: got %b want %b", n, obs_s.stall, exp_s.stall); end
            if (obs_s.ready !== exp_s.ready) begin tests_failed++; $display("FAIL rnd_ready@%0d: got %b want %b", n, obs_s.ready, exp_s.ready); end
            if (obs_s.pend !== exp_s.pend) begin tests_failed++; $display("FAIL rnd_pending@%0d: got %h want %h", n, obs_s.pend, exp_s.pend); end
            if (obs_s.rw !== exp_s.rw) begin tests_failed++; $display("FAIL rnd_rw@%0d: got %b want %b", n, obs_s.rw, exp_s.rw); end
            if (exp_s.rw) begin
                tests_run++;
                if (obs_s.wr !== exp_s.wr || obs_s.wd !== exp_s.wd) begin
                    tests_failed++; $display("FAIL rnd_write@%0d: got x%0d=%h want x%0d=%h", n, obs_s.wr, obs_s.wd, exp_s.wr, exp_s.wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_lsu_only();
        test_contention();
        test_full();
        test_x0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_wb_arbiter
